// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto a single-port word memory, one access per three cycles.
// Optional MEM_ARB_RR_EN selects round-robin tie-breaking; default is fixed data priority.
//
// state  | meaning
// IDLE   | sample requests, issue grant, latch command
// ACCESS | read or write strobe asserted for one cycle
// RESP   | memory data valid; capture it and pulse done into next IDLE
module mem_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // one extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                port_d_q, port_d_d;
  logic                range_ok_q, range_ok_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic                if_err_q, if_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_done_q, d_done_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                idle_ok;
  logic                prefer_d;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic                sel_in_range;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;  // 1: data wins the next tie

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (if_gnt)     rr_ptr_d = 1'b1;
    else if (d_gnt) rr_ptr_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) rr_ptr_q <= 1'b1;
    else          rr_ptr_q <= rr_ptr_d;
  end

  assign prefer_d = rr_ptr_q;
`else
  assign prefer_d = 1'b1;
`endif

  assign idle_ok = (state_q == IDLE) && reset_n;
  assign d_gnt   = idle_ok && d_req && (prefer_d || !if_req);
  assign if_gnt  = idle_ok && if_req && !d_gnt;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    port_d_d     = port_d_q;
    range_ok_d   = range_ok_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_done_d    = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_done_d     = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    sel_addr     = d_gnt ? d_addr : if_addr;
    sel_we       = d_gnt && d_we;
    sel_in_range = ({1'b0, sel_addr} < DEPTH_EXT);

    case (state_q)
      IDLE: begin
        if (d_gnt || if_gnt) begin
          we_d        = sel_we;
          port_d_d    = d_gnt;
          range_ok_d  = sel_in_range;
          mem_addr_d  = sel_addr;
          mem_read_d  = !sel_we && sel_in_range;
          mem_write_d = sel_we && sel_in_range;
          if (sel_we) mem_wdata_d = d_wdata;
          state_d     = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (port_d_q) begin
          d_done_d = 1'b1;
          d_err_d  = !range_ok_q;
          if (!we_q) d_rdata_d = range_ok_q ? mem_rdata : '0;
        end else begin
          if_done_d = 1'b1;
          if_err_d  = !range_ok_q;
          if (!we_q) if_rdata_d = range_ok_q ? mem_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      port_d_q    <= 1'b0;
      range_ok_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      port_d_q    <= port_d_d;
      range_ok_q  <= range_ok_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read 256-word memory model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        if_req, if_gnt, if_done, if_err;
  logic [15:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_done, d_err;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_read, mem_write, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:255];

  mem_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  // Full data-port access starting in an IDLE cycle; ends one cycle after done.
  task automatic d_op(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic exp_err, input logic [15:0] exp_rdata);
    logic inr;
    inr     = (addr < 16'd256);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    smp();
    chk("d_gnt", {d_gnt, if_gnt}, 2'b10);
    tick();
    d_req = 1'b0;
    smp();
    chk("acc_strobe", {mem_read, mem_write}, {!we && inr, we && inr});
    chk("acc_addr", mem_addr, addr);
    if (we && inr) chk("acc_wdata", mem_wdata, wdata);
    tick();
    smp();
    chk("resp_strobe", {mem_read, mem_write, busy}, 3'b001);
    tick();
    smp();
    chk("d_done", {d_done, d_err}, {1'b1, exp_err});
    chk("d_rdata", d_rdata, exp_rdata);
    tick();
  endtask

  initial begin
    logic first_d;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem_rdata = 16'h0000;
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 16'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;

    // reset state, grants forced low while reset_n low
    tick(); tick();
    smp();
    chk("rst_gnt", {d_gnt, if_gnt}, 2'b00);
    chk("rst_busy_strobe", {busy, mem_read, mem_write}, 3'b000);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_rdata", {d_rdata, if_rdata}, 32'h0);
    chk("rst_done_err", {d_done, d_err, if_done, if_err}, 4'b0000);
    tick();
    d_req = 1'b0; if_req = 1'b0; reset_n = 1'b1;

    // 1: write then read back
    d_op(1'b1, 16'h00A5, 16'h1234, 1'b0, 16'h0000);
    d_op(1'b0, 16'h00A5, 16'h0000, 1'b0, 16'h1234);

    // 3: top legal address, first illegal address, far illegal address
    d_op(1'b1, 16'h00FF, 16'hBEEF, 1'b0, 16'h1234);
    d_op(1'b1, 16'h0100, 16'h5555, 1'b1, 16'h1234);
    d_op(1'b0, 16'h00FF, 16'h0000, 1'b0, 16'hBEEF);
    d_op(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    d_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000);

    // 2: simultaneous requests
    d_op(1'b1, 16'h0010, 16'hABCD, 1'b0, 16'h0000);
    d_op(1'b1, 16'h0020, 16'h2222, 1'b0, 16'h0000);
    first_d = !RR;
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    smp();
    chk("t2_gnt0", {d_gnt, if_gnt}, {first_d, !first_d});
    tick();
    if (first_d) d_req = 1'b0; else if_req = 1'b0;
    smp();
    chk("t2_c1", {d_gnt, if_gnt, busy}, 3'b001);
    tick(); tick();
    smp();
    chk("t2_c3_done", {d_done, if_done}, {first_d, !first_d});
    chk("t2_c3_gnt", {d_gnt, if_gnt}, {!first_d, first_d});
    tick();
    d_req = 1'b0; if_req = 1'b0;
    tick(); tick();
    smp();
    chk("t2_c6_done", {d_done, if_done}, {!first_d, first_d});
    chk("t2_if_rdata", if_rdata, 16'hABCD);
    chk("t2_d_rdata", d_rdata, 16'h2222);
    tick();

    // 4: both requests held for four grants, from a fresh reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    if_req = 1'b1; if_addr = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t4_gnt", {d_gnt, if_gnt}, (RR && (i % 2 == 1)) ? 2'b01 : 2'b10);
      tick();
      if (i == 3) begin
        d_req = 1'b0; if_req = 1'b0;
      end
      tick(); tick();
    end
    smp();
    chk("t4_last_done", {d_done, if_done}, {!RR, RR});
    chk("t4_d_rdata", d_rdata, 16'h2222);
    tick();

    // 5: reset during ACCESS drops the read
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    smp();
    chk("t5_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; reset_n = 1'b0;
    smp();
    chk("t5_access_read", mem_read, 1'b1);
    tick();
    reset_n = 1'b1;
    smp();
    chk("t5_after_rst", {mem_read, busy, d_done}, 3'b000);
    chk("t5_d_rdata", d_rdata, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      smp();
      chk("t5_no_done", d_done, 1'b0);
    end
    tick();
    d_op(1'b0, 16'h0010, 16'h0000, 1'b0, 16'hABCD);

    // 6: back-to-back fetches
    d_op(1'b1, 16'h0000, 16'h1000, 1'b0, 16'hABCD);
    d_op(1'b1, 16'h0001, 16'h1001, 1'b0, 16'hABCD);
    d_op(1'b1, 16'h0002, 16'h1002, 1'b0, 16'hABCD);
    if_req = 1'b1; if_addr = 16'h0000;
    smp();
    chk("t6_c0", {if_gnt, busy}, 2'b10);
    tick();
    if_addr = 16'h0001;
    smp();
    chk("t6_c1", {if_gnt, busy}, 2'b01);
    tick();
    smp();
    chk("t6_c2", {if_gnt, busy}, 2'b01);
    tick();
    smp();
    chk("t6_c3", {if_gnt, if_done, if_err, busy}, 4'b1100);
    chk("t6_c3_rdata", if_rdata, 16'h1000);
    tick();
    if_addr = 16'h0002;
    tick(); tick();
    smp();
    chk("t6_c6", {if_gnt, if_done, if_err, busy}, 4'b1100);
    chk("t6_c6_rdata", if_rdata, 16'h1001);
    tick();
    if_req = 1'b0;
    tick(); tick();
    smp();
    chk("t6_c9", {if_gnt, if_done, if_err, busy}, 4'b0100);
    chk("t6_c9_rdata", if_rdata, 16'h1002);
    chk("t6_d_rdata_hold", {d_rdata, d_done}, {16'hABCD, 1'b0});
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
